// File: rtl/bus_control_sequencer.sv
// bus_control_sequencer: clocked 8259-style bus/control decode.
// Samples the CPU strobes on clk, commits each write once the write strobe
// is released, and steps through the ICW1..ICW4 initialisation sequence.
// Every command-word strobe leaves as a single-cycle registered pulse.
module bus_control_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter bit SINGLE_ONLY = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  CS,
  input  logic                  rd_enable,
  input  logic                  wr_enable,
  input  logic                  A1,
  input  logic [DATA_WIDTH-1:0] bi_data_bus,
  output logic [DATA_WIDTH-1:0] internal_bus,
  output logic                  write_ICW1,
  output logic                  write_ICW2,
  output logic                  write_ICW3,
  output logic                  write_ICW4,
  output logic                  write_OCW1,
  output logic                  write_OCW2,
  output logic                  write_OCW3,
  output logic                  read,
  output logic [1:0]            read_sel,
  output logic                  init_done,
  output logic                  bus_error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ICW2,
    ST_WAIT_ICW3,
    ST_WAIT_ICW4,
    ST_READY
  } state_t;

  // Bit positions inside the one-hot strobe register
  localparam int STB_ICW1 = 0;
  localparam int STB_ICW2 = 1;
  localparam int STB_ICW3 = 2;
  localparam int STB_ICW4 = 3;
  localparam int STB_OCW1 = 4;
  localparam int STB_OCW2 = 5;
  localparam int STB_OCW3 = 6;

  // Sequencer state
  state_t                  state_q, state_d;
  logic                    sngl_q, sngl_d;
  logic                    ic4_q, ic4_d;
  logic [1:0]              rr_ris_q, rr_ris_d;
  logic [6:0]              strobe_q, strobe_d;
  logic                    init_done_q;

  // Write capture / datapath state
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    a1_q, a1_d;
  logic                    pending_q, pending_d;
  logic [DATA_WIDTH-1:0]   bus_q, bus_d;
  logic                    read_q, read_d;
  logic [1:0]              read_sel_q, read_sel_d;
  logic                    bus_error_q, bus_error_d;

  logic                    wr_act;
  logic                    rd_act;
  logic                    commit;
  logic                    cmd_err;
  logic [7:0]              cmd;

  // A write is only committed once the strobe has gone away, so a held
  // strobe (or back-to-back strobes with no gap) merges into one commit.
  assign wr_act = ~CS & ~wr_enable;
  assign rd_act = ~CS & ~rd_enable;
  assign commit = pending_q & ~wr_act;
  assign cmd    = data_q[7:0];

  // Next-state decode of the committed word and the strobe it raises
  always_comb begin
    state_d  = state_q;
    sngl_d   = sngl_q;
    ic4_d    = ic4_q;
    rr_ris_d = rr_ris_q;
    strobe_d = '0;
    cmd_err  = 1'b0;
    if (commit) begin
      if (!a1_q && cmd[4]) begin
        // ICW1 restarts initialisation from any state
        strobe_d[STB_ICW1] = 1'b1;
        sngl_d             = cmd[1] | SINGLE_ONLY;
        ic4_d              = cmd[0];
        rr_ris_d           = 2'b00;
        state_d            = ST_WAIT_ICW2;
      end else begin
        case (state_q)
          ST_WAIT_ICW2: begin
            if (a1_q) begin
              strobe_d[STB_ICW2] = 1'b1;
              if (!sngl_q) begin
                state_d = ST_WAIT_ICW3;
              end else if (ic4_q) begin
                state_d = ST_WAIT_ICW4;
              end else begin
                state_d = ST_READY;
              end
            end else begin
              cmd_err = 1'b1;
            end
          end
          ST_WAIT_ICW3: begin
            if (a1_q) begin
              strobe_d[STB_ICW3] = 1'b1;
              state_d            = ic4_q ? ST_WAIT_ICW4 : ST_READY;
            end else begin
              cmd_err = 1'b1;
            end
          end
          ST_WAIT_ICW4: begin
            if (a1_q) begin
              strobe_d[STB_ICW4] = 1'b1;
              state_d            = ST_READY;
            end else begin
              cmd_err = 1'b1;
            end
          end
          ST_READY: begin
            // With A1=0 bit 4 is already known clear here; bit 3 picks OCW2/OCW3
            if (a1_q) begin
              strobe_d[STB_OCW1] = 1'b1;
            end else if (cmd[3]) begin
              strobe_d[STB_OCW3] = 1'b1;
              if (cmd[1]) begin
                rr_ris_d = cmd[1:0];
              end
            end else begin
              strobe_d[STB_OCW2] = 1'b1;
            end
          end
          default: begin
            // IDLE: nothing but ICW1 is meaningful before initialisation
            cmd_err = 1'b1;
          end
        endcase
      end
    end
  end

  // Sequencer registers; init_done is registered alongside the state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sngl_q      <= 1'b0;
      ic4_q       <= 1'b0;
      rr_ris_q    <= 2'b00;
      strobe_q    <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sngl_q      <= sngl_d;
      ic4_q       <= ic4_d;
      rr_ris_q    <= rr_ris_d;
      strobe_q    <= strobe_d;
      init_done_q <= (state_d == ST_READY);
    end
  end

  // Capture/commit of write data plus read tracking and error reporting
  always_comb begin
    data_d    = data_q;
    a1_d      = a1_q;
    pending_d = pending_q;
    bus_d     = bus_q;
    if (wr_act) begin
      data_d    = bi_data_bus;
      a1_d      = A1;
      pending_d = 1'b1;
    end else if (pending_q) begin
      bus_d     = data_q;
      pending_d = 1'b0;
    end
    read_d = rd_act & ~wr_act;
    if (A1) begin
      read_sel_d = 2'b10;
    end else if (rr_ris_q == 2'b11) begin
      read_sel_d = 2'b01;
    end else begin
      read_sel_d = 2'b00;
    end
    bus_error_d = (rd_act & wr_act) | cmd_err;
  end

  // Datapath registers; reset drops any write that was still pending
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q      <= '0;
      a1_q        <= 1'b0;
      pending_q   <= 1'b0;
      bus_q       <= '0;
      read_q      <= 1'b0;
      read_sel_q  <= 2'b00;
      bus_error_q <= 1'b0;
    end else begin
      data_q      <= data_d;
      a1_q        <= a1_d;
      pending_q   <= pending_d;
      bus_q       <= bus_d;
      read_q      <= read_d;
      read_sel_q  <= read_sel_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign internal_bus = bus_q;
  assign write_ICW1   = strobe_q[STB_ICW1];
  assign write_ICW2   = strobe_q[STB_ICW2];
  assign write_ICW3   = strobe_q[STB_ICW3];
  assign write_ICW4   = strobe_q[STB_ICW4];
  assign write_OCW1   = strobe_q[STB_OCW1];
  assign write_OCW2   = strobe_q[STB_OCW2];
  assign write_OCW3   = strobe_q[STB_OCW3];
  assign read         = read_q;
  assign read_sel     = read_sel_q;
  assign init_done    = init_done_q;
  assign bus_error    = bus_error_q;

  // At most one command-word strobe can be active in any cycle
  assert property (@(posedge clk) disable iff (!reset_n) $onehot0(strobe_q));

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Testbench for bus_control_sequencer: directed init/OCW scenarios with
// literal expectations, then randomized bus traffic against a queue-based
// model of the initialisation sequence, compared every cycle.
module tb_bus_control_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a1;
  logic [7:0] din;

  logic [7:0] internal_bus;
  logic       write_ICW1, write_ICW2, write_ICW3, write_ICW4;
  logic       write_OCW1, write_OCW2, write_OCW3;
  logic       read;
  logic [1:0] read_sel;
  logic       init_done;
  logic       bus_error;
  logic [6:0] dut_stb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_control_sequencer #(.DATA_WIDTH(8), .SINGLE_ONLY(1'b0)) dut (
    .clk          (clk),
    .reset_n      (rst_n),
    .CS           (cs_n),
    .rd_enable    (rd_n),
    .wr_enable    (wr_n),
    .A1           (a1),
    .bi_data_bus  (din),
    .internal_bus (internal_bus),
    .write_ICW1   (write_ICW1),
    .write_ICW2   (write_ICW2),
    .write_ICW3   (write_ICW3),
    .write_ICW4   (write_ICW4),
    .write_OCW1   (write_OCW1),
    .write_OCW2   (write_OCW2),
    .write_OCW3   (write_OCW3),
    .read         (read),
    .read_sel     (read_sel),
    .init_done    (init_done),
    .bus_error    (bus_error)
  );

  assign dut_stb = {write_OCW3, write_OCW2, write_OCW1,
                    write_ICW4, write_ICW3, write_ICW2, write_ICW1};

  // Strobe ids: 0 none, 1..4 ICW1..ICW4, 5 OCW1, 6 OCW2, 7 OCW3
  function automatic logic [6:0] stb_vec(input int idx);
    logic [6:0] v;
    v = 7'd0;
    if (idx > 0) v[idx-1] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The init sequence is modelled as a queue of ICW numbers still owed.
  bit         m_valid = 1'b0;
  bit         m_pend;
  logic [7:0] m_data;
  logic       m_a1;
  int         m_owed[$];
  bit         m_started;
  logic [1:0] m_rr;
  int         e_idx;
  logic [7:0] e_bus;
  logic       e_read;
  logic [1:0] e_sel;
  logic       e_init;
  logic       e_err;

  task automatic model_commit(input logic ca1, input logic [7:0] d);
    if (!ca1 && d[4]) begin
      e_idx = 1;
      m_owed.delete();
      m_owed.push_back(2);
      if (!d[1]) m_owed.push_back(3);
      if (d[0]) m_owed.push_back(4);
      m_started = 1'b1;
      m_rr = 2'b00;
    end else if (ca1 && m_started && m_owed.size() > 0) begin
      e_idx = m_owed.pop_front();
    end else if (m_started && m_owed.size() == 0 && ca1) begin
      e_idx = 5;
    end else if (m_started && m_owed.size() == 0 && d[4:3] == 2'b00) begin
      e_idx = 6;
    end else if (m_started && m_owed.size() == 0 && d[4:3] == 2'b01) begin
      e_idx = 7;
      if (d[1]) m_rr = d[1:0];
    end else begin
      e_err = 1'b1;
    end
  endtask

  task automatic model_step();
    logic wr, rd;
    wr = !cs_n && !wr_n;
    rd = !cs_n && !rd_n;
    if (!rst_n) begin
      m_valid = 1'b1;
      m_pend = 1'b0; m_data = 8'h00; m_a1 = 1'b0;
      m_owed.delete(); m_started = 1'b0; m_rr = 2'b00;
      e_idx = 0; e_bus = 8'h00; e_read = 1'b0; e_sel = 2'b00;
      e_init = 1'b0; e_err = 1'b0;
    end else begin
      e_idx  = 0;
      e_err  = rd && wr;
      e_read = rd && !wr;
      e_sel  = a1 ? 2'b10 : ((m_rr == 2'b11) ? 2'b01 : 2'b00);
      if (wr) begin
        m_data = din; m_a1 = a1; m_pend = 1'b1;
      end else if (m_pend) begin
        m_pend = 1'b0;
        e_bus  = m_data;
        model_commit(m_a1, m_data);
      end
      e_init = m_started && (m_owed.size() == 0);
    end
  endtask

  // Model advances on each edge, DUT outputs compared 1 time unit later
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (m_valid) begin
        check("model_strobes", dut_stb, stb_vec(e_idx));
        check("model_internal_bus", internal_bus, e_bus);
        check("model_read", read, e_read);
        check("model_read_sel", read_sel, e_sel);
        check("model_init_done", init_done, e_init);
        check("model_bus_error", bus_error, e_err);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic bus_write(input logic a_in, input logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; a1 = a_in; din = d;
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1; a1 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a1 = 1'b0; din = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // T1: reset asserted in the middle of a write discards it
    @(negedge clk); cs_n = 1'b0; wr_n = 1'b0; a1 = 1'b0; din = 8'h13;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); cs_n = 1'b1; wr_n = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    next_cycle();
    check("T1_strobes", dut_stb, 7'd0);
    check("T1_internal_bus", internal_bus, 8'h00);
    check("T1_init_done", init_done, 1'b0);
    check("T1_read", read, 1'b0);
    check("T1_read_sel", read_sel, 2'b00);
    check("T1_bus_error", bus_error, 1'b0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check("T1_no_strobe_after_release", dut_stb, 7'd0);
    end

    // T2: full init with cascade and ICW4
    bus_write(1'b0, 8'h11); check("T2_ICW1", dut_stb, 7'b0000001);
    check("T2_init_done_low", init_done, 1'b0);
    bus_write(1'b1, 8'h20); check("T2_ICW2", dut_stb, 7'b0000010);
    bus_write(1'b1, 8'h04); check("T2_ICW3", dut_stb, 7'b0000100);
    bus_write(1'b1, 8'h01); check("T2_ICW4", dut_stb, 7'b0001000);
    check("T2_init_done", init_done, 1'b1);
    check("T2_internal_bus", internal_bus, 8'h01);
    next_cycle(); check("T2_strobe_one_cycle", dut_stb, 7'd0);

    // T3: single mode without ICW4, then OCW1
    bus_write(1'b0, 8'h12); check("T3_ICW1", dut_stb, 7'b0000001);
    bus_write(1'b1, 8'h08); check("T3_ICW2", dut_stb, 7'b0000010);
    check("T3_init_done", init_done, 1'b1);
    bus_write(1'b1, 8'hFF); check("T3_OCW1", dut_stb, 7'b0010000);
    check("T3_internal_bus", internal_bus, 8'hFF);

    // T4: OCW2/OCW3 decode and read select
    bus_write(1'b0, 8'h20); check("T4_OCW2", dut_stb, 7'b0100000);
    bus_write(1'b0, 8'h0B); check("T4_OCW3", dut_stb, 7'b1000000);
    next_cycle(); check("T4_read_sel_isr", read_sel, 2'b01);
    bus_write(1'b0, 8'h0A); check("T4_OCW3_irr", dut_stb, 7'b1000000);
    next_cycle(); check("T4_read_sel_irr", read_sel, 2'b00);
    @(negedge clk); cs_n = 1'b0; rd_n = 1'b0; a1 = 1'b1;
    next_cycle();
    check("T4_read", read, 1'b1);
    check("T4_read_sel_imr", read_sel, 2'b10);
    @(negedge clk); cs_n = 1'b1; rd_n = 1'b1; a1 = 1'b0;
    next_cycle(); check("T4_read_drop", read, 1'b0);

    // T5: illegal word during WAIT_ICW3, then re-init from READY
    bus_write(1'b0, 8'h11); check("T5_ICW1", dut_stb, 7'b0000001);
    bus_write(1'b1, 8'h20); check("T5_ICW2", dut_stb, 7'b0000010);
    bus_write(1'b0, 8'h20);
    check("T5_no_strobe", dut_stb, 7'd0);
    check("T5_bus_error", bus_error, 1'b1);
    check("T5_bus_updated", internal_bus, 8'h20);
    bus_write(1'b1, 8'h04); check("T5_ICW3", dut_stb, 7'b0000100);
    bus_write(1'b1, 8'h01); check("T5_ICW4", dut_stb, 7'b0001000);
    check("T5_ready", init_done, 1'b1);
    bus_write(1'b0, 8'h13); check("T5_reinit_ICW1", dut_stb, 7'b0000001);
    check("T5_init_done_low", init_done, 1'b0);
    bus_write(1'b1, 8'h30); check("T5_reinit_ICW2", dut_stb, 7'b0000010);
    bus_write(1'b1, 8'h01); check("T5_reinit_ICW4", dut_stb, 7'b0001000);
    check("T5_ready_again", init_done, 1'b1);

    // T6: read/write contention, then merged back-to-back writes
    @(negedge clk); cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; a1 = 1'b1; din = 8'hAA;
    next_cycle();
    check("T6_contention_error", bus_error, 1'b1);
    check("T6_contention_read", read, 1'b0);
    @(negedge clk); cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    next_cycle();
    check("T6_contention_commit", dut_stb, 7'b0010000);
    check("T6_error_cleared", bus_error, 1'b0);
    @(negedge clk); cs_n = 1'b0; wr_n = 1'b0; a1 = 1'b1; din = 8'hAA;
    @(negedge clk); din = 8'h55;
    next_cycle(); check("T6_no_early_commit", dut_stb, 7'd0);
    @(negedge clk); cs_n = 1'b1; wr_n = 1'b1; a1 = 1'b0;
    next_cycle();
    check("T6_merged_OCW1", dut_stb, 7'b0010000);
    check("T6_merged_data", internal_bus, 8'h55);
    next_cycle(); check("T6_single_pulse", dut_stb, 7'd0);

    // Randomized traffic, checked only by the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      cs_n  = ($urandom_range(0, 7) == 0);
      wr_n  = ($urandom_range(0, 9) >= 4);
      rd_n  = ($urandom_range(0, 9) >= 2);
      a1    = ($urandom_range(0, 9) >= 4);
      din   = 8'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a1 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
